uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the Uart8 receiver.
- Captures one byte per completed frame from Uart8 (rxOut, rxDone, rxErr).
- Stores bytes in a show-ahead FIFO so the consumer logic can drain them at its own pace.
- Reports fill level, full/empty, and a sticky overflow flag.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2.
DATA_WIDTH, 8, byte width; matches Uart8 rxOut.

Ports:
clk  input  1  system clock (12 MHz on Alhambra).
reset  input  1  asynchronous, active-low reset.
rxDone  input  1  frame-complete level from Uart8; may stay high for several cycles.
rxErr  input  1  frame error from Uart8; sampled together with rxDone.
rxByte  input  DATA_WIDTH  received byte from Uart8 rxOut.
rdEn  input  1  pop request from consumer.
rdData  output  DATA_WIDTH  head entry; valid while rdValid is high.
rdValid  output  1  FIFO not empty.
rdErr  output  1  frame-error tag of head entry (only with the optional feature; otherwise tied 0).
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
overflow  output  1  sticky; a byte was lost because the FIFO was full.
clearOverflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset low, asynchronous):
  - count=0, rdValid=0, full=0, overflow=0, rdErr=0, rdData=0.
  - Pointers=0, capture FSM=IDLE.
  - Storage contents are not reset.
- Capture FSM, registered, 2 states:
  - IDLE: on a cycle where rxDone=1, push {rxErr, rxByte} and go to HOLD.
  - HOLD: stay while rxDone=1; return to IDLE when rxDone=0.
  - Result: exactly one push per rxDone assertion, whatever its width. A 1-cycle rxDone pulse pushes once.
- Push and pop timing:
  - Push write happens at the clock edge where IDLE sees rxDone=1.
  - rdValid/rdData reflect the new entry after that edge (1-cycle latency from rxDone high to rdValid).
  - Pop: rdEn && rdValid advances the read pointer at the edge. rdData shows the next entry in the following cycle (show-ahead).
  - rdEn with rdValid=0 is ignored; count stays at 0.
- Simultaneous push and pop:
  - When not empty, both occur; count unchanged.
  - When empty, push only; a pop cannot occur while rdValid=0.
  - When full, both occur; the byte is accepted and overflow is not set.
- Full:
  - A push with full=1 and no pop in the same cycle is dropped. The stored data is untouched and overflow is set to 1.
  - overflow stays 1 until clearOverflow=1.
  - If set and clear happen in the same cycle, set wins.
- Pointers: log2(DEPTH) bits, wrap naturally modulo DEPTH. count is a separate up/down counter.
- full and rdValid are derived combinationally from count.
- Reset asserted mid-operation empties the FIFO immediately. A rxDone still high after reset release is treated as a new frame (IDLE sees 1 and pushes).

Optional Feature:
Macro UART_RX_FIFO_ERR_TAG_EN.
- Defined:
  - Entries are DATA_WIDTH+1 bits wide.
  - Frames with rxErr=1 are stored, with rdErr presenting the head entry's tag.
- Undefined:
  - Entries are DATA_WIDTH bits wide; rdErr is tied 0.
  - A frame with rxErr=1 is discarded: no push and no overflow effect. The FSM still goes to HOLD.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_WIDTH=8.
  - The capture FSM state typedef (IDLE, HOLD).
  - A function returning the count width from DEPTH.
- One sub-module, uart_rx_fifo_mem:
  - Dual-pointer storage array with a synchronous write port and a combinational read port.
  - Width = DATA_WIDTH (+1 with the macro).
- Top level holds the FSM, pointers, count and flags.

Test Plan:
1. Reset then idle: reset low for 10 cycles, then high -> count=0, rdValid=0, full=0, overflow=0 throughout.
2. Single frame: rxByte=8'h55 with rxDone high for 5 cycles -> exactly one push; next cycle rdValid=1, rdData=8'h55, count=1. Pulse rdEn for 1 cycle -> rdValid=0, count=0.
3. Order and wrap: push 8'h00..8'h13 (20 bytes) while popping every other cycle, DEPTH=16 -> bytes are read back in order across the pointer wrap, no overflow.
4. Overflow: push 17 bytes (8'hA0..8'hB0) with no pops -> full=1 after the 16th; overflow=1 after the 17th; reads return A0..AF; B0 is lost. Assert clearOverflow -> overflow=0.
5. Full push+pop: FIFO full, rxDone rising edge and rdEn in the same cycle -> count stays 16, overflow stays 0, and the new byte is read last.
6. Error frame, rxByte=8'h3C with rxErr=1:
   - With macro: rdErr=1, rdData=8'h3C.
   - Without macro: rdValid stays 0, count=0.
   - Plus: reset pulled low with count=5 -> count=0 and rdValid=0 asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side byte buffer.
// Holds the byte width, the capture FSM state type and a count-width helper.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_HOLD = 1'b1
    } cap_state_e;

    // Occupancy runs 0..depth inclusive, so one bit more than the pointers.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for uart_rx_fifo: synchronous write port, combinational read.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o. Contents not reset.
module uart_rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO behind the Uart8 receiver: one push per rxDone assertion,
// level/full/empty reporting and a sticky overflow flag.
// Ports: clk, reset (async active-low), rxDone, rxErr, rxByte, rdEn, rdData,
// rdValid, rdErr, count, full, overflow, clearOverflow.
// Optional macro UART_RX_FIFO_ERR_TAG_EN: store frame-error tag per entry
// (rdErr shows head tag); when undefined, error frames are discarded.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rxDone,
    input  logic                        rxErr,
    input  logic [DATA_WIDTH-1:0]       rxByte,
    input  logic                        rdEn,
    output logic [DATA_WIDTH-1:0]       rdData,
    output logic                        rdValid,
    output logic                        rdErr,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        overflow,
    input  logic                        clearOverflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam int EW = DATA_WIDTH + 1;
`else
    localparam int EW = DATA_WIDTH;
`endif

    cap_state_e    cap_state_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          frame_start;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic [EW-1:0] wdata;
    logic [EW-1:0] head;

    assign frame_start = (cap_state_q == CAP_IDLE) && rxDone;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign push_req = frame_start;
    assign wdata    = {rxErr, rxByte};
`else
    // Bad frames are dropped here; the FSM still enters HOLD.
    assign push_req = frame_start && !rxErr;
    assign wdata    = rxByte;
`endif

    assign full    = (count_q == CW'(DEPTH));
    assign rdValid = (count_q != '0);
    assign pop     = rdEn && rdValid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Set beats clear when both land in the same cycle.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clearOverflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_state_q <= CAP_IDLE;
        end else begin
            unique case (cap_state_q)
                CAP_IDLE: if (rxDone) cap_state_q <= CAP_HOLD;
                CAP_HOLD: if (!rxDone) cap_state_q <= CAP_IDLE;
                default:  cap_state_q <= CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Storage is not reset, so gate the head while empty.
    assign rdData   = rdValid ? head[DATA_WIDTH-1:0] : '0;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign rdErr    = rdValid & head[DATA_WIDTH];
`else
    assign rdErr    = 1'b0;
`endif
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed tables, corner sequences
// and a randomized phase compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxDone, rxErr, rdEn, clearOverflow;
    logic [7:0] rxByte;
    logic [7:0] rdData;
    logic       rdValid, rdErr, full, overflow;
    logic [4:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .rxDone        (rxDone),
        .rxErr         (rxErr),
        .rxByte        (rxByte),
        .rdEn          (rdEn),
        .rdData        (rdData),
        .rdValid       (rdValid),
        .rdErr         (rdErr),
        .count         (count),
        .full          (full),
        .overflow      (overflow),
        .clearOverflow (clearOverflow)
    );

    // Reference model: a queue of {err, byte}, a sticky flag, and the last
    // rxDone level (one push per rising assertion of rxDone).
    logic [8:0] mq[$];
    logic [7:0] popped[$];
    bit         m_ovf;
    bit         m_prev_done;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf       = 0;
        m_prev_done = 0;
    endtask

    task automatic model_update(input logic d, e, input logic [7:0] b,
                                input logic re, cl);
        bit take, set;
        take = d && !m_prev_done;
        m_prev_done = d;
`ifndef UART_RX_FIFO_ERR_TAG_EN
        if (e) take = 0;
`endif
        set = 0;
        if (re && mq.size() > 0) begin
            popped.push_back(mq[0][7:0]);
            void'(mq.pop_front());
        end
        if (take) begin
            if (mq.size() < DEPTH) mq.push_back({e, b});
            else set = 1;
        end
        if (set) m_ovf = 1;
        else if (cl) m_ovf = 0;
    endtask

    task automatic compare_model();
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("rdValid", 32'(rdValid), 32'(n != 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("rdData", 32'(rdData), (n != 0) ? 32'(mq[0][7:0]) : 32'd0);
        chk("rdErr", 32'(rdErr), (n != 0) ? 32'(mq[0][8]) : 32'd0);
    endtask

    // Inputs are driven 1 time unit after an edge and sampled after the next.
    task automatic step(input logic d, e, input logic [7:0] b,
                        input logic re, cl);
        rxDone = d; rxErr = e; rxByte = b; rdEn = re; clearOverflow = cl;
        @(posedge clk);
        #1;
        model_update(d, e, b, re, cl);
        compare_model();
    endtask

    task automatic frame(input logic [7:0] b, input logic e);
        step(1'b1, e, b, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic       done;
        logic       err;
        logic [7:0] b;
        logic       rden;
        logic       clr;
        int         exp_cnt;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t vt[10];

    initial begin
        reset = 1'b0; rxDone = 0; rxErr = 0; rxByte = 0; rdEn = 0;
        clearOverflow = 0;
        model_reset();

        // 1: reset held for 10 cycles, then idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_count", 32'(count), 0);
            chk("rst_valid", 32'(rdValid), 0);
            chk("rst_full", 32'(full), 0);
            chk("rst_ovf", 32'(overflow), 0);
            chk("rst_data", 32'(rdData), 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 0);

        // 2: single long frame, table driven
        vt[0] = '{1, 0, 8'h55, 0, 0, 1, 1, 8'h55, 0};
        vt[1] = '{1, 0, 8'h55, 0, 0, 1, 1, 8'h55, 0};
        vt[2] = '{1, 0, 8'h55, 0, 0, 1, 1, 8'h55, 0};
        vt[3] = '{1, 0, 8'h55, 0, 0, 1, 1, 8'h55, 0};
        vt[4] = '{1, 0, 8'h55, 0, 0, 1, 1, 8'h55, 0};
        vt[5] = '{0, 0, 8'h00, 0, 0, 1, 1, 8'h55, 0};
        vt[6] = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
        vt[7] = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
        vt[8] = '{1, 0, 8'h66, 0, 0, 1, 1, 8'h66, 0};
        vt[9] = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
        for (int i = 0; i < 10; i++) begin
            step(vt[i].done, vt[i].err, vt[i].b, vt[i].rden, vt[i].clr);
            chk("tbl_count", 32'(count), 32'(vt[i].exp_cnt));
            chk("tbl_valid", 32'(rdValid), 32'(vt[i].exp_valid));
            chk("tbl_data", 32'(rdData), 32'(vt[i].exp_data));
            chk("tbl_ovf", 32'(overflow), 32'(vt[i].exp_ovf));
        end

        // 3: 20 bytes in order across the pointer wrap, popping every other cycle
        popped.delete();
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 8'(i), 0, 0);
            step(0, 0, 8'h00, 1, 0);
        end
        while (mq.size() > 0) pop1();
        chk("wrap_npop", 32'(popped.size()), 20);
        for (int i = 0; i < 20 && i < popped.size(); i++)
            chk("wrap_order", 32'(popped[i]), 32'(i));
        chk("wrap_ovf", 32'(overflow), 0);

        // 4: overflow on the 17th byte
        for (int i = 0; i < 17; i++) begin
            frame(8'hA0 + 8'(i), 0);
            if (i == 15) chk("ovf_full16", 32'(full), 1);
            if (i == 15) chk("ovf_not_yet", 32'(overflow), 0);
        end
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_data", 32'(rdData), 32'(8'hA0 + 8'(i)));
            pop1();
        end
        chk("ovf_empty", 32'(rdValid), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        step(0, 0, 8'h00, 0, 1);
        chk("ovf_clear", 32'(overflow), 0);

        // set wins over clear in the same cycle
        for (int i = 0; i < 16; i++) frame(8'(i), 0);
        step(1, 0, 8'h77, 0, 1);
        chk("ovf_set_wins", 32'(overflow), 1);
        step(0, 0, 8'h00, 0, 1);
        chk("ovf_clear2", 32'(overflow), 0);
        while (mq.size() > 0) pop1();

        // 5: push and pop together while full
        for (int i = 0; i < 16; i++) frame(8'hC0 + 8'(i), 0);
        step(1, 0, 8'hEE, 1, 0);
        chk("fpp_count", 32'(count), 16);
        chk("fpp_ovf", 32'(overflow), 0);
        step(0, 0, 8'h00, 0, 0);
        popped.delete();
        while (mq.size() > 0) pop1();
        chk("fpp_last", 32'(popped[popped.size()-1]), 32'hEE);
        chk("fpp_first", 32'(popped[0]), 32'hC1);

        // 6: error frame
        frame(8'h3C, 1);
`ifdef UART_RX_FIFO_ERR_TAG_EN
        chk("err_rdErr", 32'(rdErr), 1);
        chk("err_data", 32'(rdData), 32'h3C);
        pop1();
`else
        chk("err_valid", 32'(rdValid), 0);
        chk("err_count", 32'(count), 0);
`endif
        frame(8'h3D, 0);
        chk("err_good_tag", 32'(rdErr), 0);
        pop1();

        // async reset with count=5, rxDone held through reset release
        for (int i = 0; i < 5; i++) frame(8'h10 + 8'(i), 0);
        chk("ar_count5", 32'(count), 5);
        rxDone = 1; rxByte = 8'h99;
        #3;
        reset = 1'b0;
        #1;
        chk("ar_count0", 32'(count), 0);
        chk("ar_valid0", 32'(rdValid), 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        step(1, 0, 8'h99, 0, 0);
        chk("ar_repush", 32'(count), 1);
        chk("ar_data", 32'(rdData), 32'h99);
        step(0, 0, 8'h00, 1, 0);

        // randomized phase: fill-biased, then drain-biased
        for (int i = 0; i < 800; i++) begin
            logic d, e, re, cl;
            d  = ($urandom_range(0, 2) != 0);
            e  = ($urandom_range(0, 4) == 0);
            re = (i < 400) ? ($urandom_range(0, 5) == 0)
                           : ($urandom_range(0, 1) == 0);
            cl = ($urandom_range(0, 15) == 0);
            step(d, e, 8'($urandom), re, cl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
